mixcol_engine: RTL and testbench
================================

// Module: mixcol_engine
// PURPOSE
//  Sequential, parametrised MixColumns / InvMixColumns engine for the 128-bit AES state.
//  Processes COLS_PER_CYCLE 32-bit columns per clock through a shared GF(2^8) column datapath.
//  Sits between ShiftRows and AddRoundKey in the iterative round core.
//  Uses a valid/ready handshake on both sides so the round FSM can stall it.
// PARAMETERS
//  COLS_PER_CYCLE  1  columns processed per BUSY cycle; legal values 1, 2, 4 (others: elaboration error)
//  INV_EN          1  1: inverse datapath built and mode honoured; 0: forward only, mode ignored
// PORTS
//  clk        in   1    rising-edge clock
//  rst        in   1    synchronous, active-high reset
//  in_valid   in   1    ip/mode valid this cycle
//  in_ready   out  1    engine can accept a state this cycle
//  mode       in   1    0 = MixColumns, 1 = InvMixColumns; sampled at input handshake
//  ip         in   128  state in; column c = ip[127-32c -: 32], row 0 = MSB byte of column
//  out_valid  out  1    op holds a finished result
//  out_ready  in   1    downstream accepts op this cycle
//  op         out  128  result state, same column/row packing as ip
//  busy       out  1    high in BUSY state
// BEHAVIOUR
//  Reset: while rst is high at a clock edge, the edge forces state=IDLE, out_valid=0, op=0, column counter=0.
//   in_ready=0 and busy=0 while rst is high; in_ready=1 from the first cycle after rst falls.
//  Let N = 4/COLS_PER_CYCLE.
//  FSM states: IDLE, BUSY, DONE.
//   IDLE: in_ready=1. On in_valid&in_ready: latch ip and mode, set counter=0, go to BUSY.
//   BUSY: each cycle compute columns counter*C .. counter*C+C-1 (C = COLS_PER_CYCLE), write them
//    into the result register, then counter+=1. After cycle N, go to DONE with out_valid=1.
//    in_ready=0. in_valid is ignored.
//   DONE: op stable, out_valid=1.
//    On out_valid&out_ready: out_valid drops next cycle, unless a new input is accepted in the same cycle.
//    in_ready = out_ready. Simultaneous output and input handshakes: latch the new state, go straight to BUSY.
//    Otherwise, on the output handshake alone, go to IDLE.
//    Without out_ready: hold in DONE indefinitely; op and out_valid stay unchanged.
//  Latency: out_valid rises exactly N+1 rising edges after the accepting edge.
//   That is 1 capture edge + N compute edges, so 2, 3 or 5 edges for C = 4, 2, 1.
//  Throughput: one block per N+1 cycles with out_ready held high.
//  Column math, all in GF(2^8) with reduction poly 0x11B:
//   forward rows use coefficients {02,03,01,01} rotated per row;
//   inverse rows use {0e,0b,0d,09} rotated per row.
//  op is updated only in BUSY. op bytes of columns not yet processed keep their previous value.
//   This is don't-care while out_valid=0.
//  ip and mode changes after the input handshake have no effect on the result in flight.
//  Reset asserted mid-BUSY or mid-DONE aborts the operation; no out_valid is produced for it.
//  Counter wraps only via the FSM; it never exceeds N-1 in BUSY.
// TESTING
//  T1 FIPS-197 forward, mode=0:
//   ip=db135345_f20a225c_01010101_c6c6c6c6 -> op=8e4da1bc_9fdc589d_01010101_c6c6c6c6.
//   out_valid must rise exactly N+1 edges after the handshake; run for C=1, 2, 4.
//  T2 inverse, mode=1: ip=8e4da1bc_9fdc589d_01010101_c6c6c6c6 -> op=db135345_f20a225c_01010101_c6c6c6c6.
//   With INV_EN=0 and mode=1, the output must equal the forward result instead.
//  T3 backpressure: hold out_ready=0 for 10 cycles after out_valid.
//   op and out_valid must stay stable; in_ready=0 throughout.
//   Then out_ready=1 -> out_valid=0 next cycle and state goes to IDLE.
//  T4 back-to-back: in DONE, drive out_ready=1 and in_valid=1 with ip=d4d4d4d5_2d26314c_00000000_01010101.
//   Both handshakes complete in the same cycle; the second result is d5d5d7d6_4d7ebdf8_00000000_01010101.
//   It must appear after N+1 edges with no idle cycle in between.
//  T5 reset mid-op: assert rst on the second BUSY cycle.
//   Next cycle: out_valid=0, op=0, busy=0. After rst deasserts, in_ready=1.
//   A fresh T1 stimulus must then give the correct result.
//  T6 input isolation: change ip and mode every cycle during BUSY; the result must equal the latched T1 answer.

Source files
------------

// File: rtl/mixcol_engine.sv
// Iterative AES MixColumns / InvMixColumns engine with valid/ready handshakes on both sides.
// COLS_PER_CYCLE column datapaths are shared across N = 4/COLS_PER_CYCLE compute cycles.
module mixcol_engine #(
  parameter int unsigned COLS_PER_CYCLE = 1,
  parameter bit          INV_EN         = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         mode,
  input  logic [127:0] ip,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] op,
  output logic         busy
);

  generate
    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
      $error("mixcol_engine: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  localparam int unsigned N    = 4 / ((COLS_PER_CYCLE == 0) ? 1 : COLS_PER_CYCLE);
  localparam logic [1:0]  LAST = 2'(N - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t       state_q, state_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         out_valid_q, out_valid_d;
  logic [127:0] op_q, op_d;
  logic [127:0] ip_q, ip_d;
  logic         mode_q, mode_d;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c, input logic inv);
    logic [7:0] a[4], m2[4], m3[4], m9[4], mb[4], md[4], me[4];
    logic [7:0] x4, x8;
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      a[i]  = c[31-8*i -: 8];
      m2[i] = xt(a[i]);
      x4    = xt(m2[i]);
      x8    = xt(x4);
      m3[i] = m2[i] ^ a[i];
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ m2[i] ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ m2[i];
    end
    // Row r uses the coefficient vector rotated right by r positions.
    for (int unsigned i = 0; i < 4; i++) begin
      if (inv)
        r[31-8*i -: 8] = me[i] ^ mb[(i+1)%4] ^ md[(i+2)%4] ^ m9[(i+3)%4];
      else
        r[31-8*i -: 8] = m2[i] ^ m3[(i+1)%4] ^ a[(i+2)%4] ^ a[(i+3)%4];
    end
    return r;
  endfunction

  assign in_ready  = !rst && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
  assign busy      = !rst && (state_q == BUSY);
  assign out_valid = out_valid_q;
  assign op        = op_q;

  always_comb begin
    logic [31:0] ip_cols[4];
    logic [31:0] op_cols[4];
    logic [1:0]  idx;
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    op_d        = op_q;
    ip_d        = ip_q;
    mode_d      = mode_q;
    idx         = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      ip_cols[i] = ip_q[127-32*i -: 32];
      op_cols[i] = op_q[127-32*i -: 32];
    end
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          ip_d    = ip;
          mode_d  = INV_EN & mode;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        for (int unsigned j = 0; j < COLS_PER_CYCLE; j++) begin
          idx          = 2'(32'(cnt_q) * COLS_PER_CYCLE + j);
          op_cols[idx] = mix_col(ip_cols[idx], mode_q);
        end
        for (int unsigned i = 0; i < 4; i++) op_d[127-32*i -: 32] = op_cols[i];
        if (cnt_q == LAST) begin
          cnt_d       = '0;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (in_valid && in_ready) begin
            ip_d    = ip;
            mode_d  = INV_EN & mode;
            cnt_d   = '0;
            state_d = BUSY;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      op_q        <= '0;
      ip_q        <= '0;
      mode_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      op_q        <= op_d;
      ip_q        <= ip_d;
      mode_q      <= mode_d;
    end
  end

endmodule

// File: tb/tb_mixcol_engine.sv
// Directed bench for mixcol_engine: four instances (C=1/2/4 with inverse, C=4 forward-only)
// checked against a queue of expected results pushed at each input handshake.
module tb_mixcol_engine;

  localparam logic [127:0] T1_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] T1_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] T4_IN  = 128'hd4d4d4d5_2d26314c_00000000_01010101;
  localparam logic [127:0] T4_OUT = 128'hd5d5d7d6_4d7ebdf8_00000000_01010101;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         in_valid[4], in_ready[4], mode[4], out_valid[4], out_ready[4], busy[4];
  logic [127:0] ip[4], op[4];

  int checks = 0;
  int errors = 0;
  logic [127:0] exp_q[$];

  mixcol_engine #(.COLS_PER_CYCLE(1), .INV_EN(1'b1)) u_c1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .mode(mode[0]),
    .ip(ip[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]), .op(op[0]), .busy(busy[0]));
  mixcol_engine #(.COLS_PER_CYCLE(2), .INV_EN(1'b1)) u_c2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .mode(mode[1]),
    .ip(ip[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]), .op(op[1]), .busy(busy[1]));
  mixcol_engine #(.COLS_PER_CYCLE(4), .INV_EN(1'b1)) u_c4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .mode(mode[2]),
    .ip(ip[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]), .op(op[2]), .busy(busy[2]));
  mixcol_engine #(.COLS_PER_CYCLE(4), .INV_EN(1'b0)) u_fwd (
    .clk(clk), .rst(rst), .in_valid(in_valid[3]), .in_ready(in_ready[3]), .mode(mode[3]),
    .ip(ip[3]), .out_valid(out_valid[3]), .out_ready(out_ready[3]), .op(op[3]), .busy(busy[3]));

  function automatic int n_of(input int k);
    case (k)
      0:       return 4;
      1:       return 2;
      default: return 1;
    endcase
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives one input handshake; returns at the first falling edge after the accepting edge.
  task automatic accept(input int k, input logic [127:0] d, input logic m, input logic [127:0] e);
    @(negedge clk);
    ip[k] = d; mode[k] = m; in_valid[k] = 1'b1;
    #1 check($sformatf("in_ready_u%0d", k), 128'(in_ready[k]), 128'd1);
    exp_q.push_back(e);
    @(negedge clk);
    in_valid[k] = 1'b0;
  endtask

  task automatic wait_valid(input int k, input bit scramble);
    int edges = 1;
    while (out_valid[k] !== 1'b1 && edges < 20) begin
      if (scramble) begin
        ip[k]   = {$urandom, $urandom, $urandom, $urandom};
        mode[k] = 1'($urandom);
      end
      @(negedge clk);
      edges++;
    end
    check($sformatf("latency_u%0d", k), 128'(edges), 128'(n_of(k) + 1));
  endtask

  task automatic collect(input int k, input string tag);
    logic [127:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    check($sformatf("%s_op_u%0d", tag, k), op[k], e);
    check($sformatf("%s_valid_u%0d", tag, k), 128'(out_valid[k]), 128'd1);
  endtask

  task automatic release_out(input int k);
    out_ready[k] = 1'b1;
    @(negedge clk);
    out_ready[k] = 1'b0;
    #1;
    check($sformatf("ov_drop_u%0d", k), 128'(out_valid[k]), 128'd0);
    check($sformatf("idle_busy_u%0d", k), 128'(busy[k]), 128'd0);
    check($sformatf("idle_in_ready_u%0d", k), 128'(in_ready[k]), 128'd1);
  endtask

  task automatic block(input int k, input logic [127:0] d, input logic m,
                       input logic [127:0] e, input string tag, input bit scramble);
    accept(k, d, m, e);
    wait_valid(k, scramble);
    collect(k, tag);
    release_out(k);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_valid[k] = 1'b0; out_ready[k] = 1'b0; mode[k] = 1'b0; ip[k] = '0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rst_in_ready_u%0d", k), 128'(in_ready[k]), 128'd0);
      check($sformatf("rst_busy_u%0d", k), 128'(busy[k]), 128'd0);
      check($sformatf("rst_out_valid_u%0d", k), 128'(out_valid[k]), 128'd0);
      check($sformatf("rst_op_u%0d", k), op[k], 128'd0);
    end
    rst = 1'b0;
    #1;
    for (int k = 0; k < 4; k++)
      check($sformatf("post_rst_in_ready_u%0d", k), 128'(in_ready[k]), 128'd1);

    // T1 forward on every instance; T2 inverse (forward-only instance must ignore mode)
    for (int k = 0; k < 4; k++) block(k, T1_IN, 1'b0, T1_OUT, "t1", 1'b0);
    for (int k = 0; k < 3; k++) block(k, T1_OUT, 1'b1, T1_IN, "t2", 1'b0);
    block(3, T1_IN, 1'b1, T1_OUT, "t2_noinv", 1'b0);

    // T3 backpressure
    accept(0, T1_IN, 1'b0, T1_OUT);
    wait_valid(0, 1'b0);
    collect(0, "t3");
    repeat (10) begin
      @(negedge clk);
      check("t3_hold_op", op[0], T1_OUT);
      check("t3_hold_valid", 128'(out_valid[0]), 128'd1);
      check("t3_hold_in_ready", 128'(in_ready[0]), 128'd0);
    end
    release_out(0);

    // T4 back-to-back on the C=2 instance
    accept(1, T1_IN, 1'b0, T1_OUT);
    wait_valid(1, 1'b0);
    collect(1, "t4a");
    out_ready[1] = 1'b1; in_valid[1] = 1'b1; ip[1] = T4_IN; mode[1] = 1'b0;
    #1 check("t4_in_ready", 128'(in_ready[1]), 128'd1);
    exp_q.push_back(T4_OUT);
    @(negedge clk);
    in_valid[1] = 1'b0; out_ready[1] = 1'b0;
    check("t4_ov_drop", 128'(out_valid[1]), 128'd0);
    check("t4_busy", 128'(busy[1]), 128'd1);
    wait_valid(1, 1'b0);
    collect(1, "t4b");
    release_out(1);

    // T5 reset on the second BUSY cycle of the C=1 instance
    @(negedge clk);
    ip[0] = T1_IN; mode[0] = 1'b0; in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t5_out_valid", 128'(out_valid[0]), 128'd0);
    check("t5_op", op[0], 128'd0);
    check("t5_busy", 128'(busy[0]), 128'd0);
    check("t5_in_ready_rst", 128'(in_ready[0]), 128'd0);
    rst = 1'b0;
    #1 check("t5_in_ready", 128'(in_ready[0]), 128'd1);
    block(0, T1_IN, 1'b0, T1_OUT, "t5_fresh", 1'b0);

    // T6 input isolation
    block(0, T1_IN, 1'b0, T1_OUT, "t6", 1'b1);
    block(1, T1_IN, 1'b0, T1_OUT, "t6", 1'b1);
    block(2, T1_OUT, 1'b1, T1_IN, "t6", 1'b1);

    check("queue_empty", 128'(exp_q.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
